// File: rtl/onewire_pkg.sv
// Shared encodings and default slot timing for the 1-Wire serial-number master.
package onewire_pkg;

  typedef enum logic [1:0] {
    CMD_RESET = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2,
    CMD_NOP   = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOW    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_REC    = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam int CNT_W         = 16;
  localparam int DEF_DW        = 64;
  localparam int DEF_T_RST_LOW = 24000;
  localparam int DEF_T_PRES    = 2800;
  localparam int DEF_T_W0_LOW  = 2400;
  localparam int DEF_T_W1_LOW  = 240;
  localparam int DEF_T_RD_LOW  = 240;
  localparam int DEF_T_RD_SMP  = 360;
  localparam int DEF_T_REC     = 120;

  // A phase of length t ends when the down-counter reaches zero, so it starts at t-1.
  function automatic logic [CNT_W-1:0] phase_load(input int t);
    return CNT_W'(t - 1);
  endfunction

endpackage

// File: rtl/onewire_sn_master_if.sv
// Request/status and line signals between the tck-side host and the 1-Wire master.
interface onewire_sn_master_if
  import onewire_pkg::*;
#(
  parameter int DW = DEF_DW
) ();
  localparam int NBW = $clog2(DW + 1);

  logic           req_tog;
  cmd_e           cmd;
  logic [NBW-1:0] nbits;
  logic [DW-1:0]  wdata;
  logic           sn_in;
  logic           sn_out;
  logic [DW-1:0]  rdata;
  logic           presence;
  logic           busy;
  logic           done_tog;
  logic           overrun;

  modport master (
    input  req_tog, cmd, nbits, wdata, sn_in,
    output sn_out, rdata, presence, busy, done_tog, overrun
  );

  modport slave (
    output req_tog, cmd, nbits, wdata, sn_in,
    input  sn_out, rdata, presence, busy, done_tog, overrun
  );
endinterface

// File: rtl/toggle_sync.sv
// Two-flop synchroniser for a toggle-encoded request, with a one-cycle pulse per level change.
module toggle_sync (
  input  logic clk,
  input  logic hard_rst,
  input  logic i_tog,
  output logic o_pulse
);
  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk or negedge hard_rst) begin
    if (!hard_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_tog;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_pulse = r_s2 ^ r_s3;
endmodule

// File: rtl/onewire_sn_master.sv
// 1-Wire master: reset/presence, bit-serial write and read slots, toggle handshake to the tck side.
module onewire_sn_master
  import onewire_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int T_RST_LOW = DEF_T_RST_LOW,
  parameter int T_PRES    = DEF_T_PRES,
  parameter int T_W0_LOW  = DEF_T_W0_LOW,
  parameter int T_W1_LOW  = DEF_T_W1_LOW,
  parameter int T_RD_LOW  = DEF_T_RD_LOW,
  parameter int T_RD_SMP  = DEF_T_RD_SMP,
  parameter int T_REC     = DEF_T_REC
) (
  input logic                 clk,
  input logic                 hard_rst,
  onewire_sn_master_if.master bus
);
  localparam int NBW = $clog2(DW + 1);

  logic             w_req;
  logic [NBW-1:0]   w_nbits_clamp;
  logic [DW-1:0]    w_wshift;

  state_e           r_state;
  cmd_e             r_cmd;
  logic [DW-1:0]    r_wdata;
  logic [DW-1:0]    r_rdata;
  logic [DW-1:0]    r_mask;
  logic [NBW-1:0]   r_left;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sn_out;
  logic             r_busy;
  logic             r_done_tog;
  logic             r_overrun;
  logic             r_presence;

  toggle_sync u_req_sync (
    .clk      (clk),
    .hard_rst (hard_rst),
    .i_tog    (bus.req_tog),
    .o_pulse  (w_req)
  );

  function automatic logic [CNT_W-1:0] low_load(input cmd_e c, input logic b);
    case (c)
      CMD_RESET: low_load = phase_load(T_RST_LOW);
      CMD_WRITE: low_load = b ? phase_load(T_W1_LOW) : phase_load(T_W0_LOW);
      default:   low_load = phase_load(T_RD_LOW);
    endcase
  endfunction

  assign w_nbits_clamp = (bus.nbits > NBW'(DW)) ? NBW'(DW) : bus.nbits;
  assign w_wshift      = r_wdata >> 1;

  // Accept happens in IDLE with busy clear; the following IDLE cycle (busy set) dispatches.
  always_ff @(posedge clk or negedge hard_rst) begin
    if (!hard_rst) begin
      r_state    <= ST_IDLE;
      r_cmd      <= CMD_NOP;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_mask     <= '0;
      r_left     <= '0;
      r_cnt      <= '0;
      r_sn_out   <= 1'b1;
      r_busy     <= 1'b0;
      r_done_tog <= 1'b0;
      r_overrun  <= 1'b0;
      r_presence <= 1'b0;
    end else begin
      if (w_req && r_busy) r_overrun <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (r_busy) begin
            r_mask <= DW'(1);
            if (r_cmd == CMD_RESET ||
                ((r_cmd == CMD_WRITE || r_cmd == CMD_READ) && r_left != '0)) begin
              r_state  <= ST_LOW;
              r_sn_out <= 1'b0;
              r_cnt    <= low_load(r_cmd, r_wdata[0]);
            end else begin
              r_state <= ST_DONE;
            end
          end else if (w_req) begin
            r_busy    <= 1'b1;
            r_overrun <= 1'b0;
            r_cmd     <= bus.cmd;
            r_wdata   <= bus.wdata;
            r_left    <= w_nbits_clamp;
            if (bus.cmd == CMD_READ) r_rdata <= '0;
          end
        end
        ST_LOW: begin
          if (r_cnt == '0) begin
            r_sn_out <= 1'b1;
            if (r_cmd == CMD_WRITE) begin
              r_state <= ST_REC;
              r_cnt   <= phase_load(T_REC);
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= (r_cmd == CMD_RESET) ? phase_load(T_PRES) : phase_load(T_RD_SMP);
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) r_state <= ST_SAMPLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ST_SAMPLE: begin
          if (r_cmd == CMD_RESET) r_presence <= ~bus.sn_in;
          else                    r_rdata    <= r_rdata | (bus.sn_in ? r_mask : '0);
          r_state <= ST_REC;
          r_cnt   <= phase_load(T_REC);
        end
        ST_REC: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (r_cmd == CMD_RESET || r_left == NBW'(1)) begin
            r_state <= ST_DONE;
          end else begin
            r_left   <= r_left - 1'b1;
            r_mask   <= r_mask << 1;
            r_wdata  <= w_wshift;
            r_state  <= ST_LOW;
            r_sn_out <= 1'b0;
            r_cnt    <= low_load(r_cmd, w_wshift[0]);
          end
        end
        ST_DONE: begin
          r_done_tog <= ~r_done_tog;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.sn_out   = r_sn_out;
  assign bus.rdata    = r_rdata;
  assign bus.presence = r_presence;
  assign bus.busy     = r_busy;
  assign bus.done_tog = r_done_tog;
  assign bus.overrun  = r_overrun;
endmodule

// File: doc/onewire_sn_master.md
ONEWIRE_SN_MASTER -- requirements
Module: onewire_sn_master

Interface
REQ-001 SHALL take parameter DW, default 64: max bits per transaction.
REQ-002 SHALL take parameter T_RST_LOW, default 24000: reset-pulse low time, clk cycles.
REQ-003 SHALL take parameter T_PRES, default 2800: release-to-presence-sample time.
REQ-004 SHALL take parameter T_W0_LOW, default 2400: write-0 low time.
REQ-005 SHALL take parameter T_W1_LOW, default 240: write-1 low time.
REQ-006 SHALL take parameter T_RD_LOW, default 240: read-slot low time.
REQ-007 SHALL take parameter T_RD_SMP, default 360: release-to-sample time in a read slot.
REQ-008 SHALL take parameter T_REC, default 120: recovery/high time after every slot and after a reset sequence.
REQ-009 SHALL have port clk, input, 1 bit: system clock.
REQ-010 SHALL have port hard_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-011 SHALL have port req_tog, input, 1 bit: request toggle from the tck domain.
REQ-012 SHALL have port cmd, input, 2 bits: 0 RESET, 1 WRITE, 2 READ, 3 NOP.
REQ-013 SHALL have port nbits, input, clog2(DW+1) bits: bit count for WRITE/READ.
REQ-014 SHALL have port wdata, input, DW bits: write data, transmitted LSB first.
REQ-015 SHALL have port sn_in, input, 1 bit: sampled line level.
REQ-016 SHALL have port sn_out, output, 1 bit: line drive; 0 pulls low, 1 releases.
REQ-017 SHALL have port rdata, output, DW bits: read data.
REQ-018 SHALL have port presence, output, 1 bit: device answered the last RESET.
REQ-019 SHALL have port busy, output, 1 bit: transaction in progress.
REQ-020 SHALL have port done_tog, output, 1 bit: toggles once per completed transaction.
REQ-021 SHALL have port overrun, output, 1 bit: sticky flag, request arrived while busy.

Function
REQ-022 SHALL synchronise req_tog with two clk flops; a request is an edge (XOR) between sync stage 2 and its delayed copy.
REQ-023 SHALL accept a request only in IDLE: latch cmd, wdata and min(nbits,DW); clear rdata to 0 for READ; clear overrun; assert busy in the same edge.
REQ-024 SHALL ignore a request seen while busy, and set overrun instead.
REQ-025 SHALL implement states IDLE, LOW, WAIT, SAMPLE, REC, DONE.
REQ-026 SHALL, for any phase of length T, make the phase last exactly T clk cycles, with a 16-bit down-counter loaded with T-1.
REQ-027 RESET: LOW for T_RST_LOW, then WAIT T_PRES with sn_out=1, then SAMPLE with presence := ~sn_in, then REC for T_REC, then DONE.
REQ-028 WRITE bit i: LOW for T_W1_LOW if wdata[i]=1 else T_W0_LOW, then REC for T_REC; i increments and DONE follows after bit nbits-1.
REQ-029 READ bit i: LOW for T_RD_LOW, WAIT T_RD_SMP, SAMPLE with rdata[i] := sn_in, REC T_REC.
REQ-030 In DONE, for one cycle: toggle done_tog, deassert busy, return to IDLE.
REQ-031 For NOP, or WRITE/READ with nbits=0: go straight to DONE with no line activity.
REQ-032 SHALL drive sn_out low only in the LOW state, and register it (no combinational output).
REQ-033 SHALL hold rdata and presence stable from DONE until the next accepted request.
REQ-034 Latency: a req_tog change settled before clk edge k gives sn_out=0 after edge k+3.

Reset
REQ-035 On hard_rst=0 the block SHALL immediately and asynchronously set sn_out=1, busy=0, done_tog=0, overrun=0, presence=0, rdata=0, sync flops=0, counter=0, state IDLE.
REQ-036 A reset mid-transaction SHALL abort the transaction with no done_tog toggle.
REQ-037 A req_tog level that differs from 0 at reset release SHALL count as one request.

Structure
REQ-038 Package onewire_pkg SHALL hold the cmd and state encodings and the default timing constants.
REQ-039 Sub-module toggle_sync SHALL hold the 2-flop synchroniser plus edge detect, and is reused for req_tog.

Verification
(Bench timing parameters: T_RST_LOW=20, T_PRES=8, T_W0_LOW=6, T_W1_LOW=2, T_RD_LOW=2, T_RD_SMP=3, T_REC=2.)
REQ-040 RESET, sn_in held 0 during SAMPLE: sn_out low for 20 cycles, presence=1, one done_tog toggle, busy high for 33 cycles.
REQ-041 WRITE nbits=4, wdata=4'b1010: low widths in order 6, 2, 6, 2, each followed by 2 high cycles, then done.
REQ-042 READ nbits=3, sn_in pattern 1,0,1 at the sample points: rdata=3'b101, upper bits 0.
REQ-043 Toggle req_tog twice during a WRITE: overrun=1, only one done_tog toggle; the next accepted request clears overrun.
REQ-044 Assert hard_rst mid-READ at bit 1: sn_out=1 and busy=0 at once, no done_tog toggle, a new RESET then runs normally.
REQ-045 nbits=0 WRITE, and nbits=DW+5 clamped to DW: no line activity with done toggled, and exactly DW slots, respectively.
